// File: rtl/clkdiv_pkg.sv
// clkdiv_pkg: shared constants, types and setting clamp for the multi-channel clock divider
package clkdiv_pkg;
  localparam int DEF_DIV_W = 16;
  typedef logic [DEF_DIV_W-1:0] div_t;
  typedef struct packed {
    div_t div;
    div_t hi;
  } div_hi_t;
  localparam div_t RST_DIV = div_t'(2);
  localparam div_t RST_HI = div_t'(1);
  // Forces period >= 2 and 1 <= high time <= period-1 so both phases are at least one cycle
  function automatic div_hi_t clamp(input div_t div, input div_t hi);
    div_t d = (div < div_t'(2)) ? div_t'(2) : div;
    return '{div: d, hi: (hi == '0) ? div_t'(1) : (hi >= d) ? d - div_t'(1) : hi};
  endfunction
endpackage

// File: rtl/clock_divider_multi_if.sv
// clock_divider_multi_if: control and output bundle of the multi-channel clock divider
interface clock_divider_multi_if #(
  parameter int NUM_CH = 4,
  parameter int DIV_W = 16
) ();
  logic [NUM_CH-1:0] enable;
  logic load;
  logic [NUM_CH-1:0] load_mask;
  logic [NUM_CH*DIV_W-1:0] divisor;
  logic [NUM_CH*DIV_W-1:0] high_time;
  logic sync_start;
  logic [NUM_CH-1:0] clock_out;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] pending;
  modport master (
    output enable, load, load_mask, divisor, high_time, sync_start,
    input clock_out, tick, pending
  );
  modport slave (
    input enable, load, load_mask, divisor, high_time, sync_start,
    output clock_out, tick, pending
  );
endinterface

// File: rtl/clkdiv_channel.sv
// clkdiv_channel: one divider channel with shadowed period/high-time applied only at period boundaries
module clkdiv_channel
  import clkdiv_pkg::*;
(
  input  logic clock_in,
  input  logic rstn,
  input  logic enable,
  input  logic load,
  input  logic sync_start,
  input  div_t divisor,
  input  div_t high_time,
  output logic clock_out,
  output logic tick,
  output logic pending
);
  div_t cnt, act_div, act_hi, shadow_div, shadow_hi;
  div_hi_t clamped;
  logic boundary, apply;
  assign clamped = clamp(divisor, high_time);
  assign boundary = enable && (sync_start || cnt == act_div - div_t'(1));
  // A disabled channel has no period in progress, so a pending setting can land at once
  assign apply = pending && (boundary || !enable);
  always_ff @(posedge clock_in) begin
    if (!rstn) begin
      cnt <= '0;
      clock_out <= 1'b0;
      tick <= 1'b0;
      pending <= 1'b0;
      act_div <= RST_DIV;
      act_hi <= RST_HI;
      shadow_div <= RST_DIV;
      shadow_hi <= RST_HI;
    end else begin
      if (load) begin
        shadow_div <= clamped.div;
        shadow_hi <= clamped.hi;
      end
      if (apply) begin
        act_div <= shadow_div;
        act_hi <= shadow_hi;
      end
      pending <= load || (pending && !apply);
      clock_out <= enable && cnt < act_hi;
      tick <= enable && cnt == '0;
      cnt <= (!enable || boundary) ? '0 : cnt + div_t'(1);
    end
  end
endmodule

// File: rtl/clock_divider_multi.sv
// clock_divider_multi: NUM_CH independent glitch-free programmable clock dividers with common phase sync
module clock_divider_multi
  import clkdiv_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int DIV_W = DEF_DIV_W
) (
  input logic clock_in,
  input logic rstn,
  clock_divider_multi_if.slave bus
);
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    clkdiv_channel u_ch (
      .clock_in   (clock_in),
      .rstn       (rstn),
      .enable     (bus.enable[i]),
      .load       (bus.load && bus.load_mask[i]),
      .sync_start (bus.sync_start),
      .divisor    (bus.divisor[i*DIV_W +: DIV_W]),
      .high_time  (bus.high_time[i*DIV_W +: DIV_W]),
      .clock_out  (bus.clock_out[i]),
      .tick       (bus.tick[i]),
      .pending    (bus.pending[i])
    );
  end
endmodule

// File: doc/clock_divider_multi.md
Name: clock_divider_multi

Overview:
- Multi-channel programmable clock divider and successor to the single-channel divider.
- Each channel generates a registered divided clock with a programmable period and programmable high time (duty cycle), plus a one-cycle tick strobe at each period start.
- Divisor/duty updates are shadowed and take effect only at a period boundary, so outputs never glitch or produce runt pulses.
- A common sync_start phase-aligns all channels. The block feeds SEEG front-end sample/ADC timing.

Parameters:
- NUM_CH, 4, number of independent divider channels.
- DIV_W, 16, width of the divisor and high-time fields; maximum period is 2^DIV_W-1 clock_in cycles.

Ports:
- clock_in  input  1  system clock.
- rstn  input  1  reset, synchronous, active-low.
- enable  input  NUM_CH  per-channel run enable.
- load  input  1  strobe; captures the divisor/high_time fields of the channels selected in load_mask.
- load_mask  input  NUM_CH  channel select for load.
- divisor  input  NUM_CH*DIV_W  per-channel period in clock_in cycles; channel i occupies [i*DIV_W +: DIV_W].
- high_time  input  NUM_CH*DIV_W  per-channel high cycles per period, same packing.
- sync_start  input  1  phase-align strobe.
- clock_out  output  NUM_CH  divided clocks, registered.
- tick  output  NUM_CH  one-cycle pulse coinciding with each clock_out rising edge.
- pending  output  NUM_CH  high while a loaded setting awaits its period boundary.

Behaviour:
- Reset (rstn=0 at a clock_in edge), all channels:
  - cnt=0, clock_out=0, tick=0, pending=0.
  - Active divisor act_div=2, active high act_hi=1; shadow registers use the same values.
  - Reset mid-period aborts immediately with no completion of the current period.
- Clamping is applied when values are captured into shadow:
  - div_c = max(divisor, 2).
  - hi_c = 1 if high_time=0; div_c-1 if high_time>=div_c; otherwise high_time.
  - Width stays DIV_W; comparisons are unsigned; no wrap is possible because cnt <= act_div-1.
- Load:
  - On load=1, each channel with load_mask[i]=1 writes shadow_div/shadow_hi and sets pending[i] on the next edge.
  - A load while pending overwrites the shadow (latest wins).
- Enabled channel, each edge:
  - clock_out <= (cnt < act_hi).
  - tick <= (cnt == 0).
  - cnt <= (cnt == act_div-1) ? 0 : cnt+1.
- Period boundary (cnt == act_div-1, enabled): if pending, act_div/act_hi <= shadow and pending <= 0. The new period starts with the new values at cnt=0.
- Disabled channel:
  - cnt held at 0; clock_out and tick driven 0 on the next edge.
  - Any pending shadow is applied immediately and pending cleared.
- Re-enable: the first enabled edge produces clock_out=1 and tick=1 (cnt=0).
- sync_start=1: for all enabled channels, the boundary action is taken this edge (cnt <= 0, pending applied). On the following edge all enabled channels show tick=1 simultaneously.
- Simultaneous events:
  - load in the same cycle as a boundary: the boundary uses the pre-edge shadow/pending. The newly loaded values set pending and apply at the next boundary.
  - sync_start together with load: as above; the new load does not apply on this sync.
  - rstn overrides everything.
- Latency:
  - clock_out/tick are one cycle after the cnt state they decode.
  - load to pending is one cycle.
- Output frequency = f_clock_in / act_div; high time = act_hi cycles; low time = act_div-act_hi cycles (both >= 1).

Decomposition:
- Package clkdiv_pkg:
  - DIV_W default constant.
  - Reset constants RST_DIV=2 and RST_HI=1.
  - A clamp function returning clamped {div, hi}.
- Sub-module clkdiv_channel: one counter with shadow/active registers, load/sync/enable handling, registered outputs.
- Top level: generates NUM_CH instances and slices the packed buses.

Test Plan:
- Reset: hold rstn=0 for 3 cycles -> clock_out=0, tick=0, pending=0. Release with enable=1 and no load -> clock_out toggles 1,0,1,0 (div 2); tick every 2 cycles.
- Duty: load ch0 div=5 hi=2, then sync_start -> clock_out pattern 1,1,0,0,0 repeating; tick on each first-high cycle; pending drops at the sync edge.
- Glitch-free update: ch0 running div=8 hi=4; load div=3 hi=1 at cnt=2 -> current period completes as 4 high/4 low, then 1 high/2 low; pending high until that boundary.
- Clamping: load divisor=0 high_time=0 -> behaves as div 2 hi 1. Load divisor=6 high_time=9 -> 5 high/1 low.
- Alignment: ch0 div=4, ch1 div=6, both free-running at different phases; assert sync_start -> tick[0] and tick[1] coincide on the next cycle, then again every 12 cycles.
- Disable/reset mid-op: drop enable[2] mid-high -> clock_out[2]=0 next edge and a pending load applies immediately. Assert rstn=0 at cnt=3 of div=7 -> all outputs 0 next edge and act_div returns to 2.
